// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the RV32I core to word-organised data memory.
// Sub-word stores use read-modify-write. Bad accesses get an error response and never reach memory.
module lsu_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_sw;
  logic                  strobe;

  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ill;
    logic mis;
    ill = we ? (f3[2] || f3 == 3'b011) : (f3[1:0] == 2'b11 || f3 == 3'b110);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return ill || mis;
  endfunction

  // f3[2] selects zero extension; f3[1:0] is the access size.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] lane,
                                                        input logic [2:0] f3);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [1:0] lane,
                                                        input logic half);
    logic [DATA_WIDTH-1:0] r;
    r = word;
    if (half) r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    else      r[{lane, 3'b000} +: 8]      = wd[7:0];
    return r;
  endfunction

  assign is_sw = we_q && (f3_q[1:0] == 2'b10);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = '0;
          err_d   = access_bad(req_we, req_funct3, req_addr[1:0]);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = is_sw ? RESP : WAIT;
      WAIT: begin
        data_d  = we_q ? store_merge(mem_rdata, wdata_q, addr_q[1:0], f3_q[0])
                       : load_extend(mem_rdata, addr_q[1:0], f3_q);
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
    end
  end

  // Data registers carry no reset; every output using them is gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    data_q  <= data_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? data_q : '0;
  assign mem_re    = (state_q == ISSUE) && !is_sw;
  assign mem_we    = ((state_q == ISSUE) && is_sw) || (state_q == WRITE);
  assign strobe    = mem_re || mem_we;
  assign mem_addr  = strobe ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = ((state_q == ISSUE) && is_sw) ? wdata_q :
                     (state_q == WRITE)            ? data_q  : '0;

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Load/store unit between the RV32I controller and word-organised data memory. It accepts one load or store request at a time and issues word-aligned memory accesses. For byte/half stores it performs read-modify-write. Load data is returned sign- or zero-extended per funct3. Misaligned or illegal accesses are rejected with an error response and never touch memory.

Parameters:
ADDR_WIDTH, 32, byte address width of req_addr and mem_addr
DATA_WIDTH, 32, memory word width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, low bytes used for sb/sh
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal funct3
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_WIDTH  word address, [1:0] always 0
mem_wdata  out  32  full word to write
mem_rdata  in  32  read data, valid the cycle after mem_re

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=1 once rst_n=1. All other outputs 0. Captured request is discarded. No mem_we may assert in any cycle after reset until a new request is accepted.
- States: IDLE, ISSUE, WAIT, WRITE, RESP. All outputs are registered or decoded from state/registers only; there is no combinational path from req_* to mem_*.
- IDLE: on req_valid&req_ready, capture we/funct3/addr/wdata.
  - Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned -> RESP with rsp_err=1, rsp_rdata=0.
  - Otherwise -> ISSUE.
- ISSUE: mem_addr={addr[31:2],2'b00}.
  - sw: mem_we=1, mem_wdata=wdata, next RESP.
  - Load, sb, sh: mem_re=1, next WAIT.
- WAIT: sample mem_rdata.
  - Load: extract lane addr[1:0] (byte) or addr[1] (half), little-endian; sign-extend for lb/lh, zero-extend for lbu/lhu; lw is unchanged. Store result in rsp_rdata, next RESP.
  - sb/sh: merge wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1], keeping the other bytes of the sampled word. Next WRITE.
- WRITE: mem_we=1, same mem_addr, mem_wdata=merged word. Next RESP.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err hold stable until rsp_ready=1. On rsp_valid&rsp_ready -> IDLE.
- rsp_valid and req_ready are never high in the same cycle.
- Latency from accept edge to first rsp_valid cycle:
  - error: 1 cycle
  - sw: 2 cycles
  - load: 3 cycles
  - sb/sh: 4 cycles
- Throughput: with rsp_ready tied high, the next request is accepted the cycle after the response handshake.
- mem_re and mem_we are mutually exclusive and each is high for exactly one cycle per access. mem_addr/mem_wdata are 0 when both strobes are low.
- req_* changes while the bridge is busy are ignored.

Test Plan:
- Loads, with preload word@0x100=0x8899AABB:
  - lb 0x101 -> rsp_rdata=0xFFFFFFAA
  - lbu 0x103 -> 0x00000088
  - lh 0x102 -> 0xFFFF8899
  - lhu 0x100 -> 0x0000AABB
  - lw 0x100 -> 0x8899AABB
  - Each load: rsp_valid 3 cycles after accept, one mem_re pulse, no mem_we.
- sb 0x102 wdata=0x12345677 on word 0x8899AABB -> mem_re then mem_we one cycle later, mem_wdata=0x8877AABB, rsp_valid 4 cycles after accept. A following lw 0x100 returns 0x8877AABB.
- sw 0x104 wdata=0xDEADBEEF -> mem_we in the first cycle after accept, mem_addr=0x104, no mem_re, rsp_valid in the next cycle.
- Errors:
  - lw 0x102 -> rsp_err=1, rsp_rdata=0
  - lh 0x101 -> rsp_err=1
  - funct3=011 -> rsp_err=1
  - In all three cases rsp_valid 1 cycle after accept and mem_re/mem_we never assert.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle.
- Reset: assert rst_n=0 during WAIT of sh 0x100 -> outputs 0 immediately, no mem_we afterwards, memory word unchanged, req_ready=1 after release.
